// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage: fetches one instruction at a
// time over req/ready, presents it to decode over valid/accept, and computes
// the next word PC from sequential, branch, jump or register targets.
module pc_fetch_unit #(
    parameter logic [29:0] RESET_VECTOR = 30'h0000_0C00
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_accept,
    output logic [31:0] pc_out,
    input  logic        branch_taken,
    input  logic [29:0] imm_ext,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic        misalign_err,
    output logic [31:0] retired_cnt
);

    localparam int unsigned PcW  = 30;
    localparam int unsigned CntW = 32;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t         state;
    logic [PcW-1:0] pc;
    logic [PcW-1:0] pcPlus1;
    logic [PcW-1:0] nextPc;
    logic           jrMisaligned;

    // Both byte addresses come straight from the PC register, so they stay
    // stable for the whole fetch wait and the whole issue wait.
    assign imem_addr = {pc, 2'b00};
    assign pc_out    = {pc, 2'b00};

    assign jrMisaligned = (jr_addr[1:0] != 2'b00);

    // Next-PC selection, priority jr > jump > branch > sequential, wraps mod 2^30
    always_comb begin
        pcPlus1 = pc + PcW'(1);
        nextPc  = pcPlus1;
        if (jr) begin
            nextPc = jr_addr[31:2];
        end else if (jump) begin
            nextPc = {pcPlus1[29:26], jump_idx};
        end else if (branch_taken) begin
            nextPc = pcPlus1 + imm_ext;
        end
    end

    // Fetch/issue FSM with registered handshake outputs and retirement state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_BOOT;
            pc           <= RESET_VECTOR;
            imem_req     <= 1'b0;
            inst_valid   <= 1'b0;
            inst         <= '0;
            misalign_err <= 1'b0;
            retired_cnt  <= '0;
        end else begin
            case (state)
                S_BOOT: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        inst       <= imem_rdata;
                        imem_req   <= 1'b0;
                        inst_valid <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (inst_accept) begin
                        pc          <= nextPc;
                        retired_cnt <= retired_cnt + CntW'(1);
                        inst_valid  <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= S_FETCH;
                        if (jr && jrMisaligned) begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= S_BOOT;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
